sprite_line_renderer: RTL



---
 rtl/sprite_line_renderer_if.sv | 55 +++++
 rtl/sprite_line_renderer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_renderer_if.sv
// Bus bundle between the sprite line renderer and its surroundings:
// object-slot writes, line control, display readout and the sprite_gen query port.
interface sprite_line_renderer_if #(
  parameter int N_OBJ = 8
);
  localparam int IDXW = $clog2(N_OBJ);

  // Handshake semantics: there is no backpressure anywhere on this bus.
  // obj_we is a single-cycle write strobe that always completes on the edge it
  // is sampled; line_start is a single-cycle pulse that is always accepted
  // (if a render is still running it is abandoned and overrun is flagged);
  // sg_state must answer combinationally, in the same cycle, for the sg_* query.

  // object slot write port
  logic            obj_we;
  logic [IDXW-1:0] obj_addr;
  logic            obj_en;
  logic [1:0]      obj_table;
  logic [8:0]      obj_number;
  logic [8:0]      obj_x;
  logic [8:0]      obj_y;

  // line control and display readout
  logic            line_start;
  logic [8:0]      next_line;
  logic [8:0]      h_pos;
  logic            pixel_out;
  logic            busy;
  logic            overrun;

  // sprite_gen query port
  logic [1:0]      sg_table;
  logic [8:0]      sg_number;
  logic [8:0]      sg_x;
  logic [8:0]      sg_y;
  logic [8:0]      sg_h_pos;
  logic [8:0]      sg_v_pos;
  logic            sg_state;

  // driver / environment side
  modport master (
    output obj_we, obj_addr, obj_en, obj_table, obj_number, obj_x, obj_y,
    output line_start, next_line, h_pos, sg_state,
    input  pixel_out, busy, overrun,
    input  sg_table, sg_number, sg_x, sg_y, sg_h_pos, sg_v_pos
  );

  // renderer side
  modport slave (
    input  obj_we, obj_addr, obj_en, obj_table, obj_number, obj_x, obj_y,
    input  line_start, next_line, h_pos, sg_state,
    output pixel_out, busy, overrun,
    output sg_table, sg_number, sg_x, sg_y, sg_h_pos, sg_v_pos
  );
endinterface

// File: rtl/sprite_line_renderer.sv
// Line-buffered sprite compositor: walks the object list during a line,
// queries sprite_gen column by column into a back buffer, and swaps
// front/back at every line_start so the display reads a stable line.
module sprite_line_renderer #(
  parameter int N_OBJ  = 8,
  parameter int LINE_W = 320
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sprite_line_renderer_if.slave       bus,
  output logic [1:0]                  o_dbg_state
);
  localparam int          IDXW = $clog2(N_OBJ);
  localparam logic [9:0]  LW10 = 10'(LINE_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // sprite height in rows; table 3 has zero height so it never hits
  function automatic logic [8:0] f_height(input logic [1:0] t);
    case (t)
      2'd0:    f_height = 9'd16;
      2'd1:    f_height = 9'd5;
      2'd2:    f_height = 9'd5;
      default: f_height = 9'd0;
    endcase
  endfunction

  // index of the last column of a sprite (width - 1)
  function automatic logic [3:0] f_last_col(input logic [1:0] t);
    case (t)
      2'd0:    f_last_col = 4'd15;
      2'd1:    f_last_col = 4'd2;
      2'd2:    f_last_col = 4'd4;
      default: f_last_col = 4'd0;
    endcase
  endfunction

  // object RAM
  logic            r_obj_en     [N_OBJ];
  logic [1:0]      r_obj_table  [N_OBJ];
  logic [8:0]      r_obj_number [N_OBJ];
  logic [8:0]      r_obj_x      [N_OBJ];
  logic [8:0]      r_obj_y      [N_OBJ];

  // line buffers
  logic [LINE_W-1:0] r_front;
  logic [LINE_W-1:0] r_back;

  // render walk state
  state_t          r_state, w_state_nxt;
  logic [IDXW-1:0] r_idx, w_idx_nxt;
  logic [3:0]      r_col, w_col_nxt;
  logic [8:0]      r_line;
  logic            r_overrun;
  logic            r_pix;

  // slot latched during CHECK; later writes to the RAM leave it alone
  logic [1:0]      r_cur_table;
  logic [8:0]      r_cur_number;
  logic [8:0]      r_cur_x;
  logic [8:0]      r_cur_y;

  logic [8:0]      w_dy;
  logic            w_hit;
  logic            w_last_slot;
  logic [9:0]      w_s;
  logic            w_in_line;
  logic            w_latch;

  // enable bits are the only slot fields that need a reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OBJ; k++) r_obj_en[k] <= 1'b0;
    end else if (bus.obj_we) begin
      r_obj_en[bus.obj_addr] <= bus.obj_en;
    end
  end

  // slot payload storage, written whenever the strobe is high
  always_ff @(posedge clk) begin
    if (bus.obj_we) begin
      r_obj_table[bus.obj_addr]  <= bus.obj_table;
      r_obj_number[bus.obj_addr] <= bus.obj_number;
      r_obj_x[bus.obj_addr]      <= bus.obj_x;
      r_obj_y[bus.obj_addr]      <= bus.obj_y;
    end
  end

  // hit test for the slot under CHECK and the draw column address
  always_comb begin
    w_dy        = r_line - r_obj_y[r_idx];
    w_hit       = r_obj_en[r_idx] && (r_obj_table[r_idx] != 2'd3) &&
                  (w_dy < f_height(r_obj_table[r_idx]));
    w_last_slot = (r_idx == IDXW'(N_OBJ - 1));
    // 10 bits so columns past 511 stay out of range instead of wrapping left
    w_s         = {1'b0, r_cur_x} + {6'd0, r_col};
    w_in_line   = (w_s < LW10);
  end

  // next-state logic; line_start overrides whatever the walk was doing
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_col_nxt   = r_col;
    w_latch     = 1'b0;
    if (bus.line_start) begin
      w_state_nxt = S_CHECK;
      w_idx_nxt   = '0;
      w_col_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_CHECK: begin
          w_latch = 1'b1;
          if (w_hit) begin
            w_state_nxt = S_DRAW;
            w_col_nxt   = '0;
          end else if (w_last_slot) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + IDXW'(1);
          end
        end
        S_DRAW: begin
          if (r_col == f_last_col(r_cur_table)) begin
            if (w_last_slot) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_CHECK;
              w_idx_nxt   = r_idx + IDXW'(1);
            end
          end else begin
            w_col_nxt = r_col + 4'd1;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM registers, current line, latched slot and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_col        <= '0;
      r_line       <= '0;
      r_overrun    <= 1'b0;
      r_cur_table  <= '0;
      r_cur_number <= '0;
      r_cur_x      <= '0;
      r_cur_y      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_col   <= w_col_nxt;
      if (bus.line_start) begin
        r_line <= bus.next_line;
        if (r_state != S_IDLE) r_overrun <= 1'b1;
      end
      if (w_latch) begin
        r_cur_table  <= r_obj_table[r_idx];
        r_cur_number <= r_obj_number[r_idx];
        r_cur_x      <= r_obj_x[r_idx];
        r_cur_y      <= r_obj_y[r_idx];
      end
    end
  end

  // buffer swap on line_start (wins over a same-cycle draw write), else OR in pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_front <= '0;
      r_back  <= '0;
    end else if (bus.line_start) begin
      r_front <= r_back;
      r_back  <= '0;
    end else if ((r_state == S_DRAW) && bus.sg_state && w_in_line) begin
      r_back[w_s[8:0]] <= 1'b1;
    end
  end

  // registered display readout, blank past the visible width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix <= 1'b0;
    end else if ({1'b0, bus.h_pos} < LW10) begin
      r_pix <= r_front[bus.h_pos];
    end else begin
      r_pix <= 1'b0;
    end
  end

  // sprite_gen query is only driven while drawing
  always_comb begin
    bus.sg_table  = '0;
    bus.sg_number = '0;
    bus.sg_x      = '0;
    bus.sg_y      = '0;
    bus.sg_h_pos  = '0;
    bus.sg_v_pos  = '0;
    if (r_state == S_DRAW) begin
      bus.sg_table  = r_cur_table;
      bus.sg_number = r_cur_number;
      bus.sg_x      = r_cur_x;
      bus.sg_y      = r_cur_y;
      bus.sg_h_pos  = w_s[8:0];
      bus.sg_v_pos  = r_line;
    end
  end

  assign bus.pixel_out = r_pix;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.overrun   = r_overrun;
  assign o_dbg_state   = r_state;
endmodule
